// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes,
// channel state enums and elaboration-time width helpers.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Index width never collapses to zero bits, even for a single register.
  function automatic int idx_width(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle between the fabric master and the register bank.
// Handshake: a transfer happens on a rising edge where VALID and READY are both
// high; once raised, VALID and its payload hold until that edge, and READY may
// be driven independently of VALID.
interface axi_lite_regbank_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational window decode: byte address -> register index, hit flags and
// the AXI response the access will receive.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int                  ADDR_W   = 32,
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REG  = 8,
  parameter int                  IDX_W    = 3,
  parameter logic [ADDR_W-1:0]   BASE     = 32'h88000000,
  parameter logic [ADDR_W-1:0]   HIGH     = 32'h880001FF,
  parameter logic [NUM_REG-1:0]  RO_MASK  = '0
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              is_write,
  output logic [IDX_W-1:0]  index,
  output logic              hit,
  output logic              ro_hit,
  output logic [1:0]        resp
);

  localparam int SHIFT = clog2(DATA_W / 8);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word;
  logic              in_win;

  // Low offset bits drop out in the shift, so unaligned addresses alias.
  always_comb begin
    offset = addr - BASE;
    word   = offset >> SHIFT;
    in_win = (addr >= BASE) && (addr <= HIGH);
    hit    = in_win && (word < ADDR_W'(NUM_REG));
    index  = word[IDX_W-1:0];
    ro_hit = hit && RO_MASK[index];
    if (!hit) begin
      resp = RESP_DECERR;
    end else if (is_write && ro_hit) begin
      resp = RESP_SLVERR;
    end else begin
      resp = RESP_OKAY;
    end
  end

endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank with byte strobes, read-only
// status registers and independent AW/W acceptance.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                                C_S_AXI_ADDR_WIDTH = 32,
  parameter int                                C_S_AXI_DATA_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0]     C_BASEADDR         = 32'h88000000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0]     C_HIGHADDR         = 32'h880001FF,
  parameter int                                C_NUM_REG          = 8,
  parameter logic [C_NUM_REG-1:0]              C_RO_MASK          = '0
) (
  input  logic                                     ACLK,
  input  logic                                     ARESET,
  axi_lite_regbank_if.slave                        s_axi,
  output logic [C_NUM_REG*C_S_AXI_DATA_WIDTH-1:0]  reg_out,
  input  logic [C_NUM_REG*C_S_AXI_DATA_WIDTH-1:0]  reg_in,
  output logic [C_NUM_REG-1:0]                     reg_wr_pulse,
  output w_state_e                                 dbg_w_state,
  output r_state_e                                 dbg_r_state
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int IDX_W = idx_width(C_NUM_REG);

  // Write channel state
  w_state_e         w_state_q, w_state_d;
  logic             aw_held_q, aw_held_d;
  logic             w_held_q, w_held_d;
  logic [AW-1:0]    aw_addr_q, aw_addr_d;
  logic [DW-1:0]    w_data_q, w_data_d;
  logic [NB-1:0]    w_strb_q, w_strb_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [DW-1:0]    regs_q [C_NUM_REG];
  logic [DW-1:0]    regs_d [C_NUM_REG];
  logic [C_NUM_REG-1:0] pulse_q, pulse_d;

  // Read channel state
  r_state_e         r_state_q, r_state_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             aw_hs, w_hs, ar_hs;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NB-1:0]    wr_strb;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [1:0]       wr_resp, rd_resp;
  logic             rd_hit, rd_ro;
  logic             wr_hit_unused, wr_ro_unused;
  logic             unused_prot;

  assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs  = s_axi.S_AXI_WVALID  & wready_q;
  assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;

  // A channel already held supplies its latched payload; otherwise the live bus.
  assign wr_addr = aw_held_q ? aw_addr_q : s_axi.S_AXI_AWADDR;
  assign wr_data = w_held_q  ? w_data_q  : s_axi.S_AXI_WDATA;
  assign wr_strb = w_held_q  ? w_strb_q  : s_axi.S_AXI_WSTRB;

  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  axi_lite_addr_decode #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .NUM_REG(C_NUM_REG),
    .IDX_W  (IDX_W),
    .BASE   (C_BASEADDR),
    .HIGH   (C_HIGHADDR),
    .RO_MASK(C_RO_MASK)
  ) u_aw_decode (
    .addr    (wr_addr),
    .is_write(1'b1),
    .index   (wr_idx),
    .hit     (wr_hit_unused),
    .ro_hit  (wr_ro_unused),
    .resp    (wr_resp)
  );

  axi_lite_addr_decode #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .NUM_REG(C_NUM_REG),
    .IDX_W  (IDX_W),
    .BASE   (C_BASEADDR),
    .HIGH   (C_HIGHADDR),
    .RO_MASK(C_RO_MASK)
  ) u_ar_decode (
    .addr    (s_axi.S_AXI_ARADDR),
    .is_write(1'b0),
    .index   (rd_idx),
    .hit     (rd_hit),
    .ro_hit  (rd_ro),
    .resp    (rd_resp)
  );

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = s_axi.S_AXI_WDATA;
          w_strb_d = s_axi.S_AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          // Errors leave the register untouched and suppress the pulse.
          if (wr_resp == RESP_OKAY) begin
            for (int b = 0; b < NB; b++) begin
              if (wr_strb[b]) begin
                regs_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
              end
            end
            pulse_d[wr_idx] = 1'b1;
          end
          bvalid_d  = 1'b1;
          bresp_d   = wr_resp;
          w_state_d = W_RESP;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Reads sample regs_q, so a same-edge write is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          if (!rd_hit) begin
            rdata_d = '0;
          end else if (rd_ro) begin
            rdata_d = reg_in[rd_idx*DW +: DW];
          end else begin
            rdata_d = regs_q[rd_idx];
          end
          rresp_d   = rd_resp;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
          arready_d = 1'b0;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      for (int i = 0; i < C_NUM_REG; i++) begin
        regs_q[i] <= '0;
      end
      pulse_q   <= '0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  for (genvar g = 0; g < C_NUM_REG; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = regs_q[g];
  end

  assign reg_wr_pulse        = pulse_q;
  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign dbg_w_state         = w_state_q;
  assign dbg_r_state         = r_state_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Bench for axi_lite_regbank: table of single transactions plus hand-written
// sequences for channel ordering, back-pressure, same-edge access and reset.
module tb_axi_lite_regbank;
  import axi_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam logic [31:0] BASE = 32'h88000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in;
  logic [NR-1:0]    reg_wr_pulse;
  w_state_e         dbg_w_state;
  r_state_e         dbg_r_state;

  axi_lite_regbank #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_BASEADDR        (32'h88000000),
    .C_HIGHADDR        (32'h880001FF),
    .C_NUM_REG         (NR),
    .C_RO_MASK         (8'h80)
  ) dut (
    .ACLK        (clk),
    .ARESET      (rst),
    .s_axi       (bus.slave),
    .reg_out     (reg_out),
    .reg_in      (reg_in),
    .reg_wr_pulse(reg_wr_pulse),
    .dbg_w_state (dbg_w_state),
    .dbg_r_state (dbg_r_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0]   model [NR];
  logic [1:0]      exp_q_b [$];
  logic [DW+1:0]   exp_q [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = model[i];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [1:0] eb;
    if (!rst && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
      if (exp_q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL bresp_unexpected: got %0h expected no response", bus.S_AXI_BRESP);
      end else begin
        eb = exp_q_b.pop_front();
        check("bresp", bus.S_AXI_BRESP, eb);
      end
    end
  end

  always @(negedge clk) begin
    logic [DW+1:0] er;
    if (!rst && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rdata_unexpected: got %0h expected no response", bus.S_AXI_RDATA);
      end else begin
        er = exp_q.pop_front();
        check("rresp", bus.S_AXI_RRESP, er[DW+1:DW]);
        check("rdata", bus.S_AXI_RDATA, er[DW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input logic [1:0] exp_resp, input logic [NR-1:0] exp_pulse);
    int cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    int idx;
    exp_q_b.push_back(exp_resp);
    @(posedge clk); #1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = (w_lead == 0);
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge clk); #1;
      cyc++;
      if (aw_fire) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_fire)  begin bus.S_AXI_WVALID  = 1'b0; w_done  = 1; end
      if (!aw_done && cyc >= w_lead) bus.S_AXI_AWVALID = 1'b1;
    end
    if (!(aw_done && w_done)) begin
      n_checks++; n_fail++;
      $display("FAIL write_handshake_timeout: got aw=%0d w=%0d expected both", aw_done, w_done);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
    end
    if (exp_resp == RESP_OKAY) begin
      idx = int'((addr - BASE) >> 2);
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    check("bvalid_after_commit", bus.S_AXI_BVALID, 1'b1);
    check("wr_pulse", reg_wr_pulse, exp_pulse);
    check("reg_out_after_write", reg_out, model_flat());
  endtask

  task automatic wait_b();
    bit done;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      done = bus.S_AXI_BVALID && bus.S_AXI_BREADY;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL b_timeout: got no B handshake expected one within 40 cycles");
    end else begin
      check("pulse_cleared", reg_wr_pulse, '0);
      check("bvalid_dropped", bus.S_AXI_BVALID, 1'b0);
    end
  endtask

  task automatic axi_read_addr(input logic [31:0] addr, input logic [1:0] exp_resp,
                               input logic [31:0] exp_data, input bit push);
    bit fire, done;
    if (push) exp_q.push_back({exp_resp, exp_data});
    @(posedge clk); #1;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      fire = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      @(posedge clk); #1;
      if (fire) begin bus.S_AXI_ARVALID = 1'b0; done = 1; end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL ar_timeout: got no AR handshake expected one within 40 cycles");
      bus.S_AXI_ARVALID = 1'b0;
    end
    check("rvalid_latency", bus.S_AXI_RVALID, 1'b1);
    check("arready_busy", bus.S_AXI_ARREADY, 1'b0);
  endtask

  task automatic wait_r();
    bit done;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      done = bus.S_AXI_RVALID && bus.S_AXI_RREADY;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL r_timeout: got no R handshake expected one within 40 cycles");
    end else begin
      check("arready_back", bus.S_AXI_ARREADY, 1'b1);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [7:0]  pulse;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish before 2 ms");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h88000004, 32'hDEADBEEF, 4'hF, RESP_OKAY,   32'h0,        8'h02};
    vecs[1]  = '{1'b0, 32'h88000004, 32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF, 8'h00};
    vecs[2]  = '{1'b1, 32'h8800001C, 32'h12345678, 4'hF, RESP_SLVERR, 32'h0,        8'h00};
    vecs[3]  = '{1'b0, 32'h8800001C, 32'h0,        4'h0, RESP_OKAY,   32'hCAFE0001, 8'h00};
    vecs[4]  = '{1'b0, 32'h88000020, 32'h0,        4'h0, RESP_DECERR, 32'h0,        8'h00};
    vecs[5]  = '{1'b1, 32'h88000200, 32'h0BADBEEF, 4'hF, RESP_DECERR, 32'h0,        8'h00};
    vecs[6]  = '{1'b1, 32'h88000000, 32'hA5A5A5A5, 4'h3, RESP_OKAY,   32'h0,        8'h01};
    vecs[7]  = '{1'b0, 32'h88000003, 32'h0,        4'h0, RESP_OKAY,   32'h0000A5A5, 8'h00};
    vecs[8]  = '{1'b1, 32'h88000008, 32'hFFFFFFFF, 4'h0, RESP_OKAY,   32'h0,        8'h04};
    vecs[9]  = '{1'b0, 32'h88000008, 32'h0,        4'h0, RESP_OKAY,   32'h0,        8'h00};
    vecs[10] = '{1'b0, 32'h87FFFFFC, 32'h0,        4'h0, RESP_DECERR, 32'h0,        8'h00};
    vecs[11] = '{1'b1, 32'h8800001A, 32'h55AA55AA, 4'hC, RESP_OKAY,   32'h0,        8'h40};
    vecs[12] = '{1'b0, 32'h88000018, 32'h0,        4'h0, RESP_OKAY,   32'h55AA0000, 8'h00};
    vecs[13] = '{1'b0, 32'h880001FC, 32'h0,        4'h0, RESP_DECERR, 32'h0,        8'h00};
    vecs[14] = '{1'b1, 32'h88000020, 32'h01020304, 4'hF, RESP_DECERR, 32'h0,        8'h00};

    for (int i = 0; i < NR; i++) model[i] = '0;
    reg_in = '0;
    reg_in[7*DW +: DW] = 32'hCAFE0001;
    reg_in[2*DW +: DW] = 32'h99999999;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = 3'b000; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0;     bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = 3'b000; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;

    // Reset values, then readiness one cycle after release.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", bus.S_AXI_AWREADY, 1'b0);
    check("rst_wready",  bus.S_AXI_WREADY,  1'b0);
    check("rst_arready", bus.S_AXI_ARREADY, 1'b0);
    check("rst_valids",  {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    check("rst_resps",   {bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 4'b0000);
    check("rst_rdata",   bus.S_AXI_RDATA, 32'h0);
    check("rst_reg_out", reg_out, '0);
    check("rst_pulse",   reg_wr_pulse, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_not_yet", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    @(negedge clk);
    check("ready_after_rst", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

    // Table of single transactions.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, vecs[i].resp, vecs[i].pulse);
        wait_b();
      end else begin
        axi_read_addr(vecs[i].addr, vecs[i].resp, vecs[i].rdata, 1'b1);
        wait_r();
      end
    end

    // W three cycles ahead of AW, partial strobes.
    axi_write(32'h88000004, 32'h11223344, 4'b0101, 3, RESP_OKAY, 8'h02);
    wait_b();
    axi_read_addr(32'h88000004, RESP_OKAY, 32'hDE22BE44, 1'b1);
    wait_r();

    // B back-pressure for five cycles.
    bus.S_AXI_BREADY = 1'b0;
    axi_write(32'h8800000C, 32'h13579BDF, 4'hF, 0, RESP_OKAY, 8'h08);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_bvalid", bus.S_AXI_BVALID, 1'b1);
      check("stall_bresp", bus.S_AXI_BRESP, RESP_OKAY);
      check("stall_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b00);
      @(posedge clk); #1;
    end
    bus.S_AXI_BREADY = 1'b1;
    wait_b();
    axi_read_addr(32'h8800000C, RESP_OKAY, 32'h13579BDF, 1'b1);
    wait_r();

    // Read and write of register 2 committing on the same edge.
    axi_write(32'h88000008, 32'h0BADF00D, 4'hF, 0, RESP_OKAY, 8'h04);
    wait_b();
    fork
      axi_write(32'h88000008, 32'h77777777, 4'hF, 0, RESP_OKAY, 8'h04);
      axi_read_addr(32'h88000008, RESP_OKAY, 32'h0BADF00D, 1'b1);
    join
    fork
      wait_b();
      wait_r();
    join
    axi_read_addr(32'h88000008, RESP_OKAY, 32'h77777777, 1'b1);
    wait_r();

    // Reset while a read response is pending.
    bus.S_AXI_RREADY = 1'b0;
    axi_read_addr(32'h88000004, RESP_OKAY, 32'hDE22BE44, 1'b0);
    @(negedge clk);
    check("pending_rdata", bus.S_AXI_RDATA, 32'hDE22BE44);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rvalid", bus.S_AXI_RVALID, 1'b0);
    check("async_reg_out", reg_out, '0);
    check("async_rdata", bus.S_AXI_RDATA, 32'h0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    bus.S_AXI_RREADY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("arready_rel0", bus.S_AXI_ARREADY, 1'b0);
    @(negedge clk);
    check("arready_rel1", bus.S_AXI_ARREADY, 1'b1);

    // Function after reset, randomised data into register 5.
    begin
      logic [31:0] rnd;
      rnd = $urandom_range(32'h7FFFFFFF, 1);
      axi_write(32'h88000014, rnd, 4'hF, 0, RESP_OKAY, 8'h20);
      wait_b();
      axi_read_addr(32'h88000014, RESP_OKAY, rnd, 1'b1);
      wait_r();
    end

    repeat (2) @(negedge clk);
    check("end_w_state", dbg_w_state, W_IDLE);
    check("end_r_state", dbg_r_state, R_IDLE);
    check("b_queue_empty", 32'(exp_q_b.size()), 32'd0);
    check("r_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
